hazard_scheduler: RTL and testbench
===================================

// Module: hazard_scheduler
// PURPOSE
//   Pipeline scheduler for the 5-stage ARM core: owns a destination scoreboard for the EXE/MEM stages.
//   Drives the decode-stage 'hazard' input, the branch flush and the global freeze on SRAM wait.
//   Sits beside ID_Stage; consumes its src1/src2/use_src1/Two_src/Dest/WB_EN/MEM_R_EN/MEM_W_EN outputs.
//   Also keeps saturating stall/flush counters and a memory-wait watchdog.
// PARAMETERS
//   REG_W      4    register-address width (src/dest)
//   CNT_W      16   width of perf counters stall_cnt, flush_cnt
//   TIMEOUT    255  max consecutive freeze cycles before mem_timeout sets
// PORTS
//   clk            in   1      rising-edge clock
//   rst            in   1      synchronous, active-high reset
//   src1, src2     in   REG_W  ID source registers
//   use_src1       in   1      src1 is a real operand
//   two_src        in   1      src2 is a real operand
//   id_wb_en       in   1      ID instruction writes a register (post-condition, pre-hazard)
//   id_mem_r_en    in   1      ID instruction is a load
//   id_mem_w_en    in   1      ID instruction is a store
//   id_dest        in   REG_W  ID destination
//   branch_taken   in   1      EXE-stage branch resolved taken
//   mem_ready      in   1      SRAM controller done with current access
//   hazard         out  1      to ID: insert bubble, hold PC and IF/ID
//   flush          out  1      clear IF/ID; ID->EXE gets bubble
//   freeze         out  1      hold every pipeline register and PC
//   mem_timeout    out  1      sticky: freeze exceeded TIMEOUT cycles
//   stall_cnt      out  CNT_W  saturating count of hazard|freeze cycles
//   flush_cnt      out  CNT_W  saturating count of flush cycles
// BEHAVIOUR
//   - Scoreboard: exe_{v,wb,mr,mw,dst}, mem_{v,wb,mr,mw,dst}; reset: all 0. rst outranks everything.
//   - Each clock with freeze=0: mem <= exe; exe <= (hazard|flush) ? bubble : {1,id_wb_en,id_mem_r_en,id_mem_w_en,id_dest}.
//   - freeze=1: scoreboard and counters except stall_cnt hold.
//   - match_X(s) = X_v & X_wb & (X_dst==s). RF is write-before-read; the WB stage is never checked.
//   - hazard (comb) = !flush & ((use_src1 & (match_exe(src1)|match_mem(src1))) | (two_src & (match_exe(src2)|match_mem(src2)))).
//   - flush (comb) = branch_taken & !freeze. Flush beats hazard in the same cycle; the killed ID op is never stalled.
//   - mem_op = mem_v & (mem_mr|mem_mw); freeze (comb) = mem_op & !mem_ready. Zero-wait when mem_ready already 1.
//   - FSM {RUN, WAIT}; reset RUN.
//     - RUN->WAIT when freeze.
//     - WAIT->RUN when mem_ready.
//     - wait_ctr clears on entry to WAIT; increments each WAIT cycle with freeze=1, saturating.
//     - wait_ctr==TIMEOUT sets mem_timeout; only rst clears it.
//   - stall_cnt += (hazard|freeze); flush_cnt += flush; both saturate at all-ones (no wrap).
//   - Reset values: hazard=flush=freeze=0 (scoreboard empty), mem_timeout=0, counters 0.
// CONFIGURATION
//   - FORWARDING_EN defined: EXE forwarding unit present. hazard only for load-use:
//     exe_v & exe_mr & exe_dst==used src. MEM-stage matches ignored.
//   - Undefined: full RAW stall as above. Ports identical in both builds.
// STRUCTURE
//   - Package pipe_pkg: REG_W, stage_entry_t {v,wb,mr,mw,dst}, BUBBLE constant, fsm_state_t {RUN,WAIT}.
//   - One sub-module sat_counter (CNT_W, inc, hold) instanced for stall_cnt and flush_cnt.
//   - Scoreboard, hazard compare and FSM inline.
// TESTING
//   - RAW: ADD R1 (wb,dst=1), next op src1=1 use_src1=1.
//     -> hazard=1 two cycles, 0 in the third; stall_cnt=2. FORWARDING_EN: hazard=0.
//   - Load-use: LDR dst=2, next two_src=1 src2=2.
//     -> hazard=1 one cycle in both builds (second cycle only without FORWARDING_EN).
//   - Branch vs hazard: branch_taken=1 while a RAW match is present.
//     -> flush=1, hazard=0, exe entry bubble next cycle, flush_cnt=1.
//   - SRAM wait: load reaches MEM, mem_ready=0 for 3 cycles.
//     -> freeze=1 ×3, FSM WAIT, scoreboard unchanged; 4th cycle freeze=0, RUN.
//   - Watchdog: TIMEOUT=4, mem_ready held 0.
//     -> mem_timeout=1 after 4th wait cycle, stays 1 after mem_ready=1 until rst.
//   - Reset mid-WAIT and counter saturation: rst -> all outputs 0, RUN.
//     CNT_W=2 with 5 stalls -> stall_cnt=3.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline scheduler: register-address width, scoreboard
// stage entry, the empty (bubble) entry and the memory-wait FSM state.
package pipe_pkg;

  localparam int unsigned REG_W = 4;

  // One in-flight instruction as seen by the scheduler.
  typedef struct packed {
    logic             v;    // slot holds a real instruction
    logic             wb;   // writes a register
    logic             mr;   // load
    logic             mw;   // store
    logic [REG_W-1:0] dst;  // destination register
  } stage_entry_t;

  localparam stage_entry_t BUBBLE = '0;

  typedef enum logic [0:0] {
    StRun,
    StWait
  } fsm_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc=1 and hold=0, sticks at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             hold,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: increment unless held or already saturated.
  always_comb begin
    count_d = count_q;
    if (inc && !hold && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_scheduler.sv
// Pipeline scheduler for the 5-stage core: EXE/MEM destination scoreboard,
// decode hazard, branch flush, SRAM-wait freeze, memory-wait watchdog and
// saturating stall/flush counters.
// Build option: define FORWARDING_EN when an EXE forwarding unit exists; the
// hazard then covers load-use only. Ports are identical in both builds.
module hazard_scheduler
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             use_src1,
  input  logic             two_src,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic             id_mem_w_en,
  input  logic [REG_W-1:0] id_dest,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             hazard,
  output logic             flush,
  output logic             freeze,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Wide enough to hold TIMEOUT itself.
  localparam int unsigned WaitW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  stage_entry_t exe_q, exe_d, mem_q, mem_d, id_entry;
  fsm_state_t   state_q, state_d;
  logic [WaitW-1:0] wait_ctr_q, wait_ctr_d;
  logic         timeout_q, timeout_d;
  logic         mem_op, raw1, raw2, stall_inc;

  assign id_entry = {1'b1, id_wb_en, id_mem_r_en, id_mem_w_en, id_dest};

  // Freeze and flush: a pending memory access stalls everything; a taken
  // branch flushes only when the pipe is actually moving.
  always_comb begin
    mem_op = mem_q.v & (mem_q.mr | mem_q.mw);
    freeze = mem_op & ~mem_ready;
    flush  = branch_taken & ~freeze;
  end

  // Source-operand hazards against in-flight producers (WB stage not checked:
  // the register file writes before it reads).
  always_comb begin
`ifdef FORWARDING_EN
    raw1 = exe_q.v & exe_q.mr & (exe_q.dst == src1);
    raw2 = exe_q.v & exe_q.mr & (exe_q.dst == src2);
`else
    raw1 = (exe_q.v & exe_q.wb & (exe_q.dst == src1)) |
           (mem_q.v & mem_q.wb & (mem_q.dst == src1));
    raw2 = (exe_q.v & exe_q.wb & (exe_q.dst == src2)) |
           (mem_q.v & mem_q.wb & (mem_q.dst == src2));
`endif
    // A flushed ID op is discarded, so it never needs a stall.
    hazard    = ~flush & ((use_src1 & raw1) | (two_src & raw2));
    stall_inc = hazard | freeze;
  end

  // Scoreboard advance: held on freeze, bubble injected on hazard or flush.
  always_comb begin
    exe_d = exe_q;
    mem_d = mem_q;
    if (!freeze) begin
      mem_d = exe_q;
      exe_d = (hazard | flush) ? BUBBLE : id_entry;
    end
  end

  // Memory-wait FSM and watchdog counter; the timeout flag is sticky.
  always_comb begin
    state_d    = state_q;
    wait_ctr_d = wait_ctr_q;
    timeout_d  = timeout_q;
    unique case (state_q)
      StRun: begin
        if (freeze) begin
          state_d    = StWait;
          wait_ctr_d = '0;
        end
      end
      StWait: begin
        if (freeze && (wait_ctr_q != '1)) begin
          wait_ctr_d = wait_ctr_q + WaitW'(1);
        end
        if (mem_ready) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
    if (freeze && (wait_ctr_d == WaitW'(TIMEOUT))) begin
      timeout_d = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      exe_q      <= BUBBLE;
      mem_q      <= BUBBLE;
      state_q    <= StRun;
      wait_ctr_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      exe_q      <= exe_d;
      mem_q      <= mem_d;
      state_q    <= state_d;
      wait_ctr_q <= wait_ctr_d;
      timeout_q  <= timeout_d;
    end
  end

  assign mem_timeout = timeout_q;

  // Stall cycles keep counting through a freeze; flushes cannot occur then.
  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (stall_inc),
    .hold (1'b0),
    .count(stall_cnt)
  );

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_flush_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (flush),
    .hold (freeze),
    .count(flush_cnt)
  );

endmodule

// File: tb/tb_hazard_scheduler.sv
// Bench for hazard_scheduler: directed scenarios then random traffic, checked
// against an in-flight-instruction model through an expectation queue.
module tb_hazard_scheduler;

  localparam int TMO = 4;

  typedef struct {
    bit       rst;
    bit [3:0] src1, src2;
    bit       use1, two, wb, mr, mw;
    bit [3:0] dest;
    bit       br, rdy;
  } stim_t;

  typedef struct {
    bit hz, fl, fr, tmo;
    int stall, flc;
  } exp_t;

  typedef struct {
    bit v, wb, ld, st;
    int dst;
  } op_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] src1 = '0, src2 = '0, id_dest = '0;
  logic use_src1 = 1'b0, two_src = 1'b0, id_wb_en = 1'b0;
  logic id_mem_r_en = 1'b0, id_mem_w_en = 1'b0, branch_taken = 1'b0, mem_ready = 1'b1;

  logic hazard, flush, freeze, mem_timeout;
  logic [15:0] stall_cnt, flush_cnt;
  logic hz_s, fl_s, fr_s, tmo_s;
  logic [1:0] stall_s, flush_s;

  always #5 clk = ~clk;

  hazard_scheduler #(.CNT_W(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .use_src1(use_src1),
    .two_src(two_src), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .id_mem_w_en(id_mem_w_en), .id_dest(id_dest), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .hazard(hazard), .flush(flush), .freeze(freeze),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_scheduler #(.CNT_W(2), .TIMEOUT(TMO)) dut_s (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .use_src1(use_src1),
    .two_src(two_src), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .id_mem_w_en(id_mem_w_en), .id_dest(id_dest), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .hazard(hz_s), .flush(fl_s), .freeze(fr_s),
    .mem_timeout(tmo_s), .stall_cnt(stall_s), .flush_cnt(flush_s)
  );

  // Reference model: the two youngest issued instructions not yet at WB.
  op_t  inflight[2];   // [0] issued last cycle, [1] the one before
  int   m_stall, m_flush, m_run;
  bit   m_tmo;
  exp_t exp_q[$];

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Does reading register r need a result the register file does not hold yet?
  function automatic bit needs(input bit [3:0] r);
`ifdef FORWARDING_EN
    return inflight[0].v && inflight[0].ld && (inflight[0].dst == int'(r));
`else
    for (int k = 0; k < 2; k++)
      if (inflight[k].v && inflight[k].wb && (inflight[k].dst == int'(r))) return 1'b1;
    return 1'b0;
`endif
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) inflight[k] = '{v: 0, wb: 0, ld: 0, st: 0, dst: 0};
    m_stall = 0; m_flush = 0; m_run = 0; m_tmo = 0;
  endfunction

  function automatic stim_t nop();
    stim_t s;
    s = '{rst: 0, src1: 0, src2: 0, use1: 0, two: 0, wb: 0, mr: 0, mw: 0,
          dest: 0, br: 0, rdy: 1};
    return s;
  endfunction

  // One clock: drive, predict, queue the prediction, advance the model.
  task automatic cycle(input stim_t s);
    exp_t e;
    rst = s.rst; src1 = s.src1; src2 = s.src2; use_src1 = s.use1; two_src = s.two;
    id_wb_en = s.wb; id_mem_r_en = s.mr; id_mem_w_en = s.mw; id_dest = s.dest;
    branch_taken = s.br; mem_ready = s.rdy;
    e.fr = inflight[1].v && (inflight[1].ld || inflight[1].st) && !s.rdy;
    e.fl = s.br && !e.fr;
    e.hz = !e.fl && ((s.use1 && needs(s.src1)) || (s.two && needs(s.src2)));
    e.tmo = m_tmo; e.stall = m_stall; e.flc = m_flush;
    exp_q.push_back(e);
    @(posedge clk);
    if (s.rst) model_reset();
    else begin
      if (!e.fr) begin
        inflight[1] = inflight[0];
        if (e.hz || e.fl) inflight[0] = '{v: 0, wb: 0, ld: 0, st: 0, dst: 0};
        else inflight[0] = '{v: 1, wb: s.wb, ld: s.mr, st: s.mw, dst: int'(s.dest)};
      end
      if (e.hz || e.fr) m_stall++;
      if (e.fl) m_flush++;
      m_run = e.fr ? m_run + 1 : 0;
      if (m_run > TMO) m_tmo = 1;
    end
    #1;
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle.
  exp_t mon_e;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("hazard", int'(hazard), int'(mon_e.hz));
      chk("flush", int'(flush), int'(mon_e.fl));
      chk("freeze", int'(freeze), int'(mon_e.fr));
      chk("mem_timeout", int'(mem_timeout), int'(mon_e.tmo));
      chk("stall_cnt", int'(stall_cnt), sat(mon_e.stall, 65535));
      chk("flush_cnt", int'(flush_cnt), sat(mon_e.flc, 65535));
      chk("stall_cnt_w2", int'(stall_s), sat(mon_e.stall, 3));
      chk("flush_cnt_w2", int'(flush_s), sat(mon_e.flc, 3));
      chk("mem_timeout_w2", int'(tmo_s), int'(mon_e.tmo));
    end
  end

  initial begin
    stim_t s;
    int low_burst;
    model_reset();
    @(posedge clk); #1;
    s = nop(); s.rst = 1; cycle(s); cycle(s);
    // RAW on R1
    s = nop(); s.wb = 1; s.dest = 1; cycle(s);
    s = nop(); s.use1 = 1; s.src1 = 1; repeat (3) cycle(s);
    // Load-use on R2 via src2
    s = nop(); s.wb = 1; s.mr = 1; s.dest = 2; cycle(s);
    s = nop(); s.two = 1; s.src2 = 2; repeat (3) cycle(s);
    // Branch against a live RAW match
    s = nop(); s.wb = 1; s.dest = 3; cycle(s);
    s = nop(); s.use1 = 1; s.src1 = 3; s.br = 1; cycle(s);
    s = nop(); repeat (2) cycle(s);
    // SRAM wait, three cycles
    s = nop(); s.wb = 1; s.mr = 1; s.dest = 5; cycle(s);
    s = nop(); cycle(s);
    s.rdy = 0; repeat (3) cycle(s);
    s = nop(); repeat (2) cycle(s);
    // Watchdog: store stuck, then released, then reset
    s = nop(); s.mw = 1; s.dest = 6; cycle(s);
    s = nop(); cycle(s);
    s.rdy = 0; repeat (7) cycle(s);
    s = nop(); repeat (3) cycle(s);
    s.rst = 1; cycle(s);
    s = nop(); cycle(s);
    // Reset in the middle of a wait
    s = nop(); s.mr = 1; s.wb = 1; s.dest = 7; cycle(s);
    s = nop(); cycle(s);
    s.rdy = 0; repeat (2) cycle(s);
    s.rst = 1; cycle(s);
    s = nop(); repeat (2) cycle(s);
    // Random traffic
    low_burst = 0;
    for (int i = 0; i < 3000; i++) begin
      s.rst  = ($urandom_range(0, 249) == 0);
      s.src1 = 4'($urandom_range(0, 3));
      s.src2 = 4'($urandom_range(0, 3));
      s.use1 = ($urandom_range(0, 3) != 0);
      s.two  = ($urandom_range(0, 1) == 0);
      s.wb   = ($urandom_range(0, 2) != 0);
      s.mr   = ($urandom_range(0, 3) == 0);
      s.mw   = !s.mr && ($urandom_range(0, 5) == 0);
      s.dest = 4'($urandom_range(0, 3));
      s.br   = ($urandom_range(0, 7) == 0);
      if (low_burst > 0) begin
        s.rdy = 0; low_burst--;
      end else if ($urandom_range(0, 39) == 0) begin
        s.rdy = 0; low_burst = $urandom_range(3, 8);
      end else begin
        s.rdy = ($urandom_range(0, 3) != 0);
      end
      cycle(s);
    end
    repeat (3) @(negedge clk);
    chk("expect_queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
